mem_ctrl: RTL and testbench

Byte-serial memory controller inside `cpu`, directly upstream of the top-level RAM/HCI memory bus. It arbitrates between the instruction-fetch unit and the load/store unit and serialises each request into little-endian byte transfers on the 8-bit bus. It reassembles read bytes across the one-cycle RAM read latency, stalls I/O stores while the HCI output buffer is full, and freezes while the CPU is paused by `rdy_in`.

---
 rtl/mem_ctrl_if.sv | 30 +++
 rtl/mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: RAM/HCI byte bus plus the fetch and load/store request ports of mem_ctrl.
// The slave modport is the controller view; the master modport is the requester/RAM view.
interface mem_ctrl_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;

  modport slave (
    input  mem_din, io_buffer_full, if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    output mem_dout, mem_a, mem_wr, if_data, if_done, ls_rdata, ls_done
  );

  modport master (
    output mem_din, io_buffer_full, if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
    input  mem_dout, mem_a, mem_wr, if_data, if_done, ls_rdata, ls_done
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and load/store onto an 8-bit little-endian RAM/HCI bus.
// Define MEMCTRL_FLUSH_EN to add flush_in, which aborts in-flight fetches.
module mem_ctrl #(
  parameter int unsigned IO_SEL_BIT = 17
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
`ifdef MEMCTRL_FLUSH_EN
  input  logic      flush_in,
`endif
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_acc;
  logic [2:0]  r_nbytes;
  logic [2:0]  r_cnt;
  logic        r_is_if;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_mem_wr;
  logic [31:0] r_if_data;
  logic [31:0] r_ls_rdata;
  logic        r_if_done;
  logic        r_ls_done;

  logic        w_flush;
  logic [31:0] w_merged;
  logic [1:0]  w_cap_lane;
  logic [2:0]  w_cnt_inc;
  logic [2:0]  w_wr_idx;
  logic [31:0] w_wr_addr;
  logic        w_wr_stall;
  logic        w_acc_stall;
  logic [2:0]  w_ls_n;

`ifdef MEMCTRL_FLUSH_EN
  assign w_flush = flush_in;
`else
  assign w_flush = 1'b0;
`endif

  always_comb begin
    // In READ, r_cnt=j presents byte j and captures byte j-1 returned by the RAM.
    w_cap_lane = r_cnt[1:0] - 2'd1;
    w_merged   = r_acc;
    if (r_cnt != 3'd0) w_merged[{w_cap_lane, 3'b000} +: 8] = bus.mem_din;
    w_cnt_inc   = r_cnt + 3'd1;
    // A stalled WRITE (r_mem_wr low) retries the same byte instead of advancing.
    w_wr_idx    = r_mem_wr ? w_cnt_inc : r_cnt;
    w_wr_addr   = r_addr + {29'd0, w_wr_idx};
    w_wr_stall  = (w_wr_addr[IO_SEL_BIT -: 2] == 2'b11) && bus.io_buffer_full;
    w_acc_stall = (bus.ls_addr[IO_SEL_BIT -: 2] == 2'b11) && bus.io_buffer_full;
    unique case (bus.ls_size)
      2'b00:   w_ls_n = 3'd1;
      2'b01:   w_ls_n = 3'd2;
      default: w_ls_n = 3'd4;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= StIdle;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_acc      <= 32'd0;
      r_nbytes   <= 3'd0;
      r_cnt      <= 3'd0;
      r_is_if    <= 1'b0;
      r_mem_a    <= 32'd0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_if_data  <= 32'd0;
      r_ls_rdata <= 32'd0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
    end else if (!rdy_in) begin
      // HCI owns the bus: hold state, drop progress so the transaction restarts at byte 0.
      r_cnt      <= 3'd0;
      r_acc      <= 32'd0;
      r_mem_wr   <= 1'b0;
      r_mem_dout <= 8'd0;
      r_mem_a    <= (r_state == StRead) ? r_addr : 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cnt      <= 3'd0;
          r_acc      <= 32'd0;
          r_mem_a    <= 32'd0;
          r_mem_wr   <= 1'b0;
          r_mem_dout <= 8'd0;
          if (bus.ls_req) begin
            r_is_if  <= 1'b0;
            r_addr   <= bus.ls_addr;
            r_wdata  <= bus.ls_wdata;
            r_nbytes <= w_ls_n;
            if (bus.ls_we) begin
              r_state <= StWrite;
              if (!w_acc_stall) begin
                r_mem_wr   <= 1'b1;
                r_mem_a    <= bus.ls_addr;
                r_mem_dout <= bus.ls_wdata[7:0];
              end
            end else begin
              r_state <= StRead;
              r_mem_a <= bus.ls_addr;
            end
          end else if (bus.if_req && !w_flush) begin
            r_is_if  <= 1'b1;
            r_addr   <= bus.if_addr;
            r_nbytes <= 3'd4;
            r_state  <= StRead;
            r_mem_a  <= bus.if_addr;
          end
        end
        StRead: begin
          if (r_is_if && w_flush) begin
            r_state <= StIdle;
            r_mem_a <= 32'd0;
          end else if (r_cnt == r_nbytes) begin
            r_state <= StDone;
            r_mem_a <= 32'd0;
            if (r_is_if) begin
              r_if_data <= w_merged;
              r_if_done <= 1'b1;
            end else begin
              r_ls_rdata <= w_merged;
              r_ls_done  <= 1'b1;
            end
          end else begin
            r_acc   <= w_merged;
            r_cnt   <= w_cnt_inc;
            r_mem_a <= (w_cnt_inc < r_nbytes) ? r_addr + {29'd0, w_cnt_inc} : 32'd0;
          end
        end
        StWrite: begin
          if (r_mem_wr && (r_cnt == r_nbytes - 3'd1)) begin
            r_state    <= StDone;
            r_mem_wr   <= 1'b0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_ls_done  <= 1'b1;
          end else begin
            r_cnt <= w_wr_idx;
            if (w_wr_stall) begin
              r_mem_wr   <= 1'b0;
              r_mem_a    <= 32'd0;
              r_mem_dout <= 8'd0;
            end else begin
              r_mem_wr   <= 1'b1;
              r_mem_a    <= w_wr_addr;
              r_mem_dout <= r_wdata[{w_wr_idx[1:0], 3'b000} +: 8];
            end
          end
        end
        StDone: begin
          r_if_done <= 1'b0;
          r_ls_done <= 1'b0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign bus.mem_a    = r_mem_a;
  assign bus.mem_dout = r_mem_dout;
  assign bus.mem_wr   = r_mem_wr & rdy_in;
  assign bus.if_data  = r_if_data;
  assign bus.if_done  = r_if_done & rdy_in;
  assign bus.ls_rdata = r_ls_rdata;
  assign bus.ls_done  = r_ls_done & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios for mem_ctrl against a one-cycle-latency byte RAM model.
// Define MEMCTRL_FLUSH_EN to also exercise the fetch flush path.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
`ifdef MEMCTRL_FLUSH_EN
  logic flush = 1'b0;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl_if bus ();

  mem_ctrl #(.IO_SEL_BIT(17)) u_dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .rdy_in   (rdy),
`ifdef MEMCTRL_FLUSH_EN
    .flush_in (flush),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // RAM: I/O addresses are not stored; unwritten bytes come from a fixed pattern.
  logic [7:0] ram [4096];
  bit         wvalid [4096];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0102: return 8'h00;
      32'h0000_0103: return 8'h00;
      32'hFFFF_FFFF: return 8'h5A;
      32'h0000_0000: return 8'hC3;
      default:       return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mem_wr && bus.mem_a[17:16] != 2'b11) begin
      ram[bus.mem_a[11:0]]    <= bus.mem_dout;
      wvalid[bus.mem_a[11:0]] <= 1'b1;
    end
    if (wvalid[bus.mem_a[11:0]] && bus.mem_a[17:16] != 2'b11) bus.mem_din <= ram[bus.mem_a[11:0]];
    else bus.mem_din <= dflt(bus.mem_a);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_tests++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a got %h want 0", bus.mem_a); end
    n_tests++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr got %b want 0", bus.mem_wr); end
    n_tests++; if (bus.mem_dout !== 8'h0) begin n_fail++; $display("FAIL reset_mem_dout got %h want 0", bus.mem_dout); end
    n_tests++; if (bus.if_data !== 32'h0) begin n_fail++; $display("FAIL reset_if_data got %h want 0", bus.if_data); end
    n_tests++; if (bus.ls_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_ls_rdata got %h want 0", bus.ls_rdata); end
    n_tests++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL reset_if_done got %b want 0", bus.if_done); end
    n_tests++; if (bus.ls_done !== 1'b0) begin n_fail++; $display("FAIL reset_ls_done got %b want 0", bus.ls_done); end
  endtask

  task automatic test_reset_mid_write();
    tick();
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b10;
    bus.ls_addr = 32'h300; bus.ls_wdata = 32'h1122_3344;
    tick();
    tick();
    n_tests++; if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_wr got %b want 1", bus.mem_wr); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL rstmid_wr got %b want 0", bus.mem_wr); end
    n_tests++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL rstmid_a got %h want 0", bus.mem_a); end
    n_tests++; if (bus.mem_dout !== 8'h0) begin n_fail++; $display("FAIL rstmid_dout got %h want 0", bus.mem_dout); end
    bus.ls_req = 1'b0; bus.ls_we = 1'b0;
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++; if (bus.ls_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done c%0d got %b want 0", c, bus.ls_done); end
      n_tests++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_wr c%0d got %b want 0", c, bus.mem_wr); end
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    tick();
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b10;
    bus.ls_addr = 32'h200; bus.ls_wdata = 32'hDEAD_BEEF;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c <= 4) begin
        n_tests++; if (bus.mem_wr !== 1'b1) begin n_fail++; $display("FAIL prio_wr c%0d got %b want 1", c, bus.mem_wr); end
        n_tests++; if (bus.mem_a !== 32'(32'h200 + c - 1)) begin n_fail++; $display("FAIL prio_a c%0d got %h want %h", c, bus.mem_a, 32'(32'h200 + c - 1)); end
        n_tests++; if (bus.mem_dout !== exp_b[c-1]) begin n_fail++; $display("FAIL prio_dout c%0d got %h want %h", c, bus.mem_dout, exp_b[c-1]); end
      end
      n_tests++; if (bus.ls_done !== (c == 5)) begin n_fail++; $display("FAIL prio_ls_done c%0d got %b want %b", c, bus.ls_done, c == 5); end
      n_tests++; if (bus.if_done !== (c == 12)) begin n_fail++; $display("FAIL prio_if_done c%0d got %b want %b", c, bus.if_done, c == 12); end
      if (c == 6) begin
        n_tests++; if (bus.mem_a !== 32'h0 || bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL prio_idle got a=%h wr=%b want a=0 wr=0", bus.mem_a, bus.mem_wr); end
      end
      if (c == 7) begin
        n_tests++; if (bus.mem_a !== 32'h200) begin n_fail++; $display("FAIL prio_fetch_a got %h want 200", bus.mem_a); end
      end
      if (c == 5) bus.ls_req = 1'b0;
      if (c == 12) begin
        n_tests++; if (bus.if_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_if_data got %h want deadbeef", bus.if_data); end
        bus.if_req = 1'b0;
      end
    end
  endtask

  task automatic test_fetch();
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) begin
        n_tests++; if (bus.mem_a !== 32'(32'h100 + c - 1)) begin n_fail++; $display("FAIL fetch_a c%0d got %h want %h", c, bus.mem_a, 32'(32'h100 + c - 1)); end
        n_tests++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL fetch_wr c%0d got %b want 0", c, bus.mem_wr); end
      end
      n_tests++; if (bus.if_done !== (c == 6)) begin n_fail++; $display("FAIL fetch_done c%0d got %b want %b", c, bus.if_done, c == 6); end
      if (c == 6) begin
        n_tests++; if (bus.if_data !== 32'h0000_0513) begin n_fail++; $display("FAIL fetch_data got %h want 00000513", bus.if_data); end
        bus.if_req = 1'b0;
      end
    end
  endtask

  task automatic test_wrap();
    tick();
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'b01; bus.ls_addr = 32'hFFFF_FFFF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        n_tests++; if (bus.mem_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_a0 got %h want ffffffff", bus.mem_a); end
      end
      if (c == 2) begin
        n_tests++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL wrap_a1 got %h want 0", bus.mem_a); end
      end
      n_tests++; if (bus.ls_done !== (c == 4)) begin n_fail++; $display("FAIL wrap_done c%0d got %b want %b", c, bus.ls_done, c == 4); end
      if (c == 4) begin
        n_tests++; if (bus.ls_rdata !== 32'h0000_C35A) begin n_fail++; $display("FAIL wrap_rdata got %h want 0000c35a", bus.ls_rdata); end
        bus.ls_req = 1'b0;
      end
    end
  endtask

  task automatic test_io_stall();
    tick();
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_size = 2'b00;
    bus.ls_addr = 32'h0003_0000; bus.ls_wdata = 32'h0000_0041;
    bus.io_buffer_full = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_tests++; if (bus.mem_wr !== (c == 4)) begin n_fail++; $display("FAIL io_wr c%0d got %b want %b", c, bus.mem_wr, c == 4); end
      n_tests++; if (bus.ls_done !== (c == 5)) begin n_fail++; $display("FAIL io_done c%0d got %b want %b", c, bus.ls_done, c == 5); end
      if (c == 3) begin
        n_tests++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL io_stall_a got %h want 0", bus.mem_a); end
        bus.io_buffer_full = 1'b0;
      end
      if (c == 4) begin
        n_tests++; if (bus.mem_a !== 32'h0003_0000) begin n_fail++; $display("FAIL io_a got %h want 00030000", bus.mem_a); end
        n_tests++; if (bus.mem_dout !== 8'h41) begin n_fail++; $display("FAIL io_dout got %h want 41", bus.mem_dout); end
      end
      if (c == 5) bus.ls_req = 1'b0;
    end
  endtask

  task automatic test_rdy_restart();
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_tests++; if (bus.if_done !== (c == 10)) begin n_fail++; $display("FAIL rdy_done c%0d got %b want %b", c, bus.if_done, c == 10); end
      if (c >= 5 && c <= 8) begin
        n_tests++; if (bus.mem_a !== 32'(32'h200 + c - 5)) begin n_fail++; $display("FAIL rdy_a c%0d got %h want %h", c, bus.mem_a, 32'(32'h200 + c - 5)); end
      end
      if (c == 10) begin
        n_tests++; if (bus.if_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdy_data got %h want deadbeef", bus.if_data); end
        bus.if_req = 1'b0;
      end
      rdy = (c == 3 || c == 4) ? 1'b0 : 1'b1;
    end
  endtask

`ifdef MEMCTRL_FLUSH_EN
  task automatic test_flush();
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_tests++; if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL flush_done c%0d got %b want 0", c, bus.if_done); end
      if (c == 2) begin
        n_tests++; if (bus.mem_a !== 32'h101) begin n_fail++; $display("FAIL flush_a1 got %h want 101", bus.mem_a); end
      end
      if (c == 4 || c == 6) begin
        n_tests++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL flush_idle_a c%0d got %h want 0", c, bus.mem_a); end
      end
      flush = (c == 3 || c == 5) ? 1'b1 : 1'b0;
      bus.if_req = (c == 5) ? 1'b1 : 1'b0;
    end
  endtask
`endif

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'b00;
    bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;
    bus.io_buffer_full = 1'b0;
    #12 rst = 1'b0;
    test_reset();
    test_reset_mid_write();
    test_priority();
    test_fetch();
    test_wrap();
    test_io_stall();
    test_rdy_restart();
`ifdef MEMCTRL_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
